frame_stream_tx: RTL and testbench
==================================

// Module: frame_stream_tx
// PURPOSE
//  Serial transmitter feeding the video-bank write path: takes packed 1-bit-per-pixel frame bytes, shifts them out MSB-first.
//  Generates SPI_clk, SPI_clk_en, chip_select, video_data_ready and the read_bank1/read_bank2 swap that the video top consumes.
//  Sits between the frame source (flash/SD reader) and video_top; one frame = FRAME_W*FRAME_H bits, row-major.
// PARAMETERS
//  FRAME_W     200  pixels per stored row (scaled width)
//  FRAME_H     150  rows per stored frame; FRAME_W*FRAME_H must be a multiple of 8 (elaboration $error otherwise)
//  CLK_DIV     4    CLK_40 cycles per bit; even, >=2 (elaboration $error otherwise)
//  GAP_CYCLES  8    CLK_40 cycles chip_select stays low between frames; >=1
// PORTS
//  CLK_40            in   1  system clock; sole clock
//  reset             in   1  asynchronous, active-low reset
//  start             in   1  1-cycle pulse; begins streaming from IDLE
//  stop              in   1  1-cycle pulse; finish current frame then return to IDLE
//  byte_data         in   8  next 8 pixels, bit7 first on the wire
//  byte_valid        in   1  byte_data valid
//  byte_ready        out  1  buffer accepts byte; transfer when valid&&ready
//  SPI_clk           out  1  serial clock, idle low
//  SPI_clk_en        out  1  1-cycle strobe per bit, aligned to SPI_clk rising edge
//  MISO              out  1  serial pixel data
//  chip_select       out  1  active-high frame envelope
//  video_data_ready  out  1  high while frame bits are being shifted
//  read_bank1        out  1  display bank 1 (receiver writes bank 2)
//  read_bank2        out  1  display bank 2 (receiver writes bank 1)
//  frame_done        out  1  1-cycle pulse after last bit of a frame
//  underrun          out  1  sticky: source starved at a byte boundary; cleared only by reset
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame): state IDLE; all outputs 0; counters, buffer and stop_pending cleared.
//  Storage: shift reg (8b) + 1-byte prefetch buffer. byte_ready = !buf_full && state!=IDLE.
//  FSM:
//    IDLE   -> SELECT on start.
//    SELECT: chip_select=1 for CLK_DIV cycles -> SHIFT.
//    SHIFT  -> GAP after last bit's final divider cycle.
//    GAP: chip_select=0 for GAP_CYCLES -> SELECT, or -> IDLE if stop_pending.
//  Bit timing (SHIFT): div_cnt 0..CLK_DIV-1.
//    SPI_clk=0 for div_cnt<CLK_DIV/2, else 1.
//    MISO updates when div_cnt==0.
//    SPI_clk_en=1 exactly when div_cnt==CLK_DIV/2.
//  Byte boundary: at div_cnt==0 of bit 0 of each byte, buffer moves into shift reg.
//    If buffer empty: stall. div_cnt holds 0, SPI_clk=0, no SPI_clk_en, MISO holds, underrun<=1. Resume the cycle after a byte lands.
//  video_data_ready=1 throughout SHIFT, including stalls; 0 elsewhere.
//  Bit counter 0..FRAME_W*FRAME_H-1, width $clog2(FRAME_W*FRAME_H); exactly FRAME_W*FRAME_H SPI_clk_en pulses per frame.
//  Frame end (SHIFT->GAP): frame_done pulses 1 cycle; banks swap.
//    First frame after reset: {read_bank1,read_bank2} 00->10.
//    Thereafter: 10<->01. Never 11.
//  start outside IDLE: ignored.
//  stop: sets stop_pending in SELECT/SHIFT/GAP; ignored in IDLE. Frame always completes; bank outputs hold in IDLE.
//  stop coincident with frame end: honored at that GAP. start and stop in same IDLE cycle: start wins, stop ignored.
//  Prefetch buffer persists across frames; bytes accepted in GAP are used by the next frame.
// TESTING (FRAME_W=8, FRAME_H=2, CLK_DIV=4, GAP_CYCLES=3)
//  1. Reset low, toggle inputs -> all outputs 0, byte_ready 0.
//  2. Reset release; start, bytes A5,3C always valid, stop mid-frame -> 16 SPI_clk_en.
//     MISO sampled = 1010010100111100; frame_done once; banks 10; IDLE.
//  3. Withhold 2nd byte 20 cycles -> SPI_clk low, no strobes during stall, underrun=1.
//     Bits still A5,3C in order; total 16 strobes.
//  4. Stream 3 frames then stop -> banks 00->10->01->10.
//     chip_select low exactly 3 cycles between frames; ends IDLE.
//  5. Assert reset at bit 9 -> same-cycle: SPI_clk, chip_select, video_data_ready, banks = 0.
//     Restart sends a full fresh 16-bit frame.
//  6. start pulse while in SHIFT -> no effect: frame length 16 bits, no extra SELECT.

Source files
------------

// File: rtl/frame_stream_tx.sv
// frame_stream_tx
//   Serialises packed 1-bit-per-pixel frame bytes MSB-first towards the
//   video-bank write path, framing each FRAME_W*FRAME_H-bit frame with
//   chip_select and swapping the display bank at every frame end.
//
// Ports
//   CLK_40            sole clock
//   reset             asynchronous, active-low reset
//   start / stop      1-cycle pulses: begin streaming / finish frame then idle
//   byte_data/valid   next 8 pixels from the frame source (bit7 first)
//   byte_ready        prefetch buffer can take a byte (valid && ready moves it)
//   SPI_clk           serial clock, idle low
//   SPI_clk_en        1-cycle strobe coinciding with each SPI_clk rising edge
//   MISO              serial pixel data
//   chip_select       frame envelope (active high)
//   video_data_ready  high while the frame is being shifted (stalls included)
//   read_bank1/2      display-bank select consumed by video_top
//   frame_done        1-cycle pulse after the last bit of a frame
//   underrun          sticky: source starved at a byte boundary
module frame_stream_tx #(
    parameter int unsigned FRAME_W    = 200,
    parameter int unsigned FRAME_H    = 150,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic       CLK_40,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       SPI_clk,
    output logic       SPI_clk_en,
    output logic       MISO,
    output logic       chip_select,
    output logic       video_data_ready,
    output logic       read_bank1,
    output logic       read_bank2,
    output logic       frame_done,
    output logic       underrun
);
    localparam int unsigned NBITS = FRAME_W * FRAME_H;
    localparam int unsigned BW    = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if ((NBITS % 8) != 0 || NBITS == 0) begin : g_bad_frame
        $error("frame_stream_tx: FRAME_W*FRAME_H must be a non-zero multiple of 8");
    end
    if ((CLK_DIV % 2) != 0 || CLK_DIV < 2) begin : g_bad_div
        $error("frame_stream_tx: CLK_DIV must be even and >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("frame_stream_tx: GAP_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SELECT, SHIFT, GAP} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   div_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [7:0]      shift_reg;
    logic [7:0]      byte_buf;
    logic            buf_full;
    logic            stop_pending;

    logic div_end, byte_start, stall, load, frame_end, gap_end, accept;

    assign div_end    = (div_cnt == DW'(CLK_DIV - 1));
    // Every byte starts on an 8-aligned bit index since NBITS is a multiple of 8.
    assign byte_start = (state == SHIFT) && (div_cnt == '0) && (bit_cnt[2:0] == 3'd0);
    assign stall      = byte_start && !buf_full;
    assign load       = byte_start && buf_full;
    assign frame_end  = (state == SHIFT) && div_end && (bit_cnt == BW'(NBITS - 1));
    assign gap_end    = (state == GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));
    assign byte_ready = !buf_full && (state != IDLE);
    assign accept     = byte_valid && byte_ready;

    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = SELECT;
            SELECT:  if (div_end)   state_nxt = SHIFT;
            SHIFT:   if (frame_end) state_nxt = GAP;
            GAP:     if (gap_end)   state_nxt = (stop_pending || stop) ? IDLE : SELECT;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            div_cnt      <= '0;
            gap_cnt      <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            byte_buf     <= '0;
            buf_full     <= 1'b0;
            stop_pending <= 1'b0;
            read_bank1   <= 1'b0;
            read_bank2   <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            // The divider also times the SELECT lead-in; a stall freezes it at 0.
            if (state_nxt != state)
                div_cnt <= '0;
            else if (state == SELECT || (state == SHIFT && !stall))
                div_cnt <= div_end ? '0 : div_cnt + 1'b1;

            if (state == GAP && state_nxt == GAP) gap_cnt <= gap_cnt + 1'b1;
            else                                  gap_cnt <= '0;

            if (state == SHIFT && div_end)
                bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;

            // MISO is shift_reg[7], so it changes on the edge closing div_cnt==0.
            if (load)
                shift_reg <= byte_buf;
            else if (state == SHIFT && div_cnt == '0 && bit_cnt[2:0] != 3'd0)
                shift_reg <= {shift_reg[6:0], 1'b0};

            // accept and load are mutually exclusive (ready needs empty, load needs full).
            if (accept) begin
                byte_buf <= byte_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end

            if (state == GAP && state_nxt == IDLE)
                stop_pending <= 1'b0;
            else if (stop && state != IDLE)
                stop_pending <= 1'b1;

            frame_done <= frame_end;
            if (frame_end) begin
                if (!read_bank1 && !read_bank2) begin
                    read_bank1 <= 1'b1;
                    read_bank2 <= 1'b0;
                end else begin
                    read_bank1 <= read_bank2;
                    read_bank2 <= read_bank1;
                end
            end

            if (stall) underrun <= 1'b1;
        end
    end

    assign SPI_clk          = (state == SHIFT) && (div_cnt >= DW'(CLK_DIV / 2));
    assign SPI_clk_en       = (state == SHIFT) && (div_cnt == DW'(CLK_DIV / 2));
    assign MISO             = shift_reg[7];
    assign chip_select      = (state == SELECT) || (state == SHIFT);
    assign video_data_ready = (state == SHIFT);

endmodule

// File: tb/tb_frame_stream_tx.sv
module tb_frame_stream_tx;
    localparam int unsigned FW  = 8;
    localparam int unsigned FH  = 2;
    localparam int unsigned DIV = 4;
    localparam int unsigned GAP = 3;
    localparam int unsigned FBITS = FW * FH;

    logic       CLK_40 = 1'b0;
    logic       reset  = 1'b0;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic [7:0] byte_data  = '0;
    logic       byte_valid = 1'b0;
    logic       byte_ready, SPI_clk, SPI_clk_en, MISO, chip_select, video_data_ready;
    logic       read_bank1, read_bank2, frame_done, underrun;
    logic [9:0] outs;

    frame_stream_tx #(.FRAME_W(FW), .FRAME_H(FH), .CLK_DIV(DIV), .GAP_CYCLES(GAP)) dut (
        .CLK_40(CLK_40), .reset(reset), .start(start), .stop(stop),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .SPI_clk(SPI_clk), .SPI_clk_en(SPI_clk_en), .MISO(MISO),
        .chip_select(chip_select), .video_data_ready(video_data_ready),
        .read_bank1(read_bank1), .read_bank2(read_bank2),
        .frame_done(frame_done), .underrun(underrun)
    );

    assign outs = {byte_ready, SPI_clk, SPI_clk_en, MISO, chip_select, video_data_ready,
                   read_bank1, read_bank2, frame_done, underrun};

    always #5 CLK_40 = ~CLK_40;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: the wire must carry every accepted byte, MSB first, in order.
    typedef struct { logic [7:0] b; int unsigned dly; } item_t;
    item_t       src_q[$];
    logic        exp_bits[$];
    bit          src_noise = 1'b0;

    // Observations gathered per cycle by the monitor.
    int unsigned strobes, fstrobes, fd_cnt, cs_rise, cs_low, lo_run, max_lo;
    bit          seen_fall, prev_sclk, prev_cs;
    logic [15:0] rx;
    int unsigned flen_q[$];
    logic [1:0]  bank_q[$];
    logic [15:0] rxq[$];
    int unsigned gap_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_bits.delete(); src_q.delete();
        flen_q.delete(); bank_q.delete(); rxq.delete(); gap_q.delete();
        strobes = 0; fstrobes = 0; fd_cnt = 0; cs_rise = 0; cs_low = 0;
        lo_run = 0; max_lo = 0; seen_fall = 0; rx = '0;
    endtask

    // Byte source: offers queued bytes after their per-byte delay.
    initial begin
        int unsigned wait_cnt = 0;
        forever begin
            @(negedge CLK_40);
            if (!reset) begin
                wait_cnt   = 0;
                byte_valid = src_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                byte_data  = 8'($urandom);
            end else if (src_q.size() > 0) begin
                if (wait_cnt < src_q[0].dly) begin
                    wait_cnt++;
                    byte_valid = 1'b0;
                end else begin
                    byte_valid = 1'b1;
                    byte_data  = src_q[0].b;
                    if (byte_ready) begin
                        for (int i = 7; i >= 0; i--) exp_bits.push_back(src_q[0].b[i]);
                        void'(src_q.pop_front());
                        wait_cnt = 0;
                    end
                end
            end else begin
                byte_valid = 1'b0;
            end
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic eb;
        forever begin
            @(negedge CLK_40);
            if (!reset) begin
                prev_sclk = 1'b0;
                prev_cs   = 1'b0;
            end else begin
                if (SPI_clk_en) begin
                    strobes++;
                    fstrobes++;
                    chk("clk_en_on_rise", {30'd0, prev_sclk, SPI_clk}, 32'd1);
                    if (exp_bits.size() == 0) begin
                        chk("bit_without_byte", 32'd1, 32'd0);
                    end else begin
                        eb = exp_bits.pop_front();
                        chk("miso_bit", {31'd0, MISO}, {31'd0, eb});
                    end
                    rx = {rx[14:0], MISO};
                end
                if (video_data_ready && !SPI_clk) lo_run++;
                else                              lo_run = 0;
                if (lo_run > max_lo) max_lo = lo_run;
                if (!chip_select && prev_cs) begin
                    seen_fall = 1'b1;
                    cs_low    = 1;
                end else if (!chip_select) begin
                    cs_low++;
                end
                if (chip_select && !prev_cs) begin
                    cs_rise++;
                    if (seen_fall) gap_q.push_back(cs_low);
                end
                if (frame_done) begin
                    fd_cnt++;
                    flen_q.push_back(fstrobes);
                    bank_q.push_back({read_bank1, read_bank2});
                    rxq.push_back(rx);
                    fstrobes = 0;
                end
                prev_sclk = SPI_clk;
                prev_cs   = chip_select;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(negedge CLK_40);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge CLK_40);
        reset = 1'b0;
        #1 clear_model();
        repeat (3) @(negedge CLK_40);
        reset = 1'b1;
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    task automatic wait_strobes(input int unsigned n);
        int unsigned c = 0;
        while (strobes < n && c < 2000) begin cycle(); c++; end
        chk("timeout_strobes", {31'd0, strobes >= n}, 32'd1);
    endtask

    task automatic wait_frames(input int unsigned n);
        int unsigned c = 0;
        while (fd_cnt < n && c < 3000) begin cycle(); c++; end
        chk("timeout_frames", {31'd0, fd_cnt >= n}, 32'd1);
    endtask

    task automatic wait_idle();
        int unsigned c = 0, run = 0;
        while (run < GAP + 3 && c < 400) begin
            cycle(); c++;
            if (!chip_select && !byte_ready && !video_data_ready) run++;
            else                                                  run = 0;
        end
        chk("idle_reached", {31'd0, run >= GAP + 3}, 32'd1);
    endtask

    task automatic push_bytes(input int unsigned n, input int unsigned max_dly);
        item_t it;
        for (int i = 0; i < int'(n); i++) begin
            it.b   = 8'($urandom);
            it.dly = $urandom_range(0, max_dly);
            src_q.push_back(it);
        end
    endtask

    initial begin
        item_t       it;
        logic [1:0]  exp_bank [3];
        logic [7:0]  b0, b1;

        clear_model();
        exp_bank[0] = 2'b10; exp_bank[1] = 2'b01; exp_bank[2] = 2'b10;

        // 1: held in reset with toggling inputs
        src_noise = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK_40);
            start = 1'($urandom_range(0, 1));
            stop  = 1'($urandom_range(0, 1));
            #1 chk("reset_outputs", {22'd0, outs}, 32'd0);
        end
        @(negedge CLK_40);
        start = 1'b0; stop = 1'b0; src_noise = 1'b0;
        @(negedge CLK_40);
        reset = 1'b1;
        #1 chk("idle_after_release", {22'd0, outs}, 32'd0);

        // 2: A5,3C with source always ready, stop mid-frame
        it.dly = 0;
        it.b = 8'hA5; src_q.push_back(it);
        it.b = 8'h3C; src_q.push_back(it);
        pulse_start();
        wait_strobes(6);
        pulse_stop();
        wait_frames(1);
        wait_idle();
        chk("t2_strobes", strobes, FBITS);
        chk("t2_frame_done", fd_cnt, 1);
        chk("t2_bits", {16'd0, rxq.size() > 0 ? rxq[0] : 16'hxxxx}, 32'h0000A53C);
        chk("t2_bank", {30'd0, read_bank1, read_bank2}, 32'd2);
        chk("t2_no_underrun", {31'd0, underrun}, 32'd0);
        chk("t2_clk_low_phase", max_lo, DIV / 2);
        chk("t2_bits_consumed", exp_bits.size(), 0);

        // 3: second byte withheld long enough to starve the byte boundary
        apply_reset();
        it.b = 8'hA5; it.dly = 0;  src_q.push_back(it);
        it.b = 8'h3C; it.dly = 50; src_q.push_back(it);
        pulse_start();
        pulse_stop();
        wait_frames(1);
        wait_idle();
        chk("t3_strobes", strobes, FBITS);
        chk("t3_bits", {16'd0, rxq.size() > 0 ? rxq[0] : 16'hxxxx}, 32'h0000A53C);
        chk("t3_underrun", {31'd0, underrun}, 32'd1);
        chk("t3_stall_clk_low", {31'd0, max_lo >= 10}, 32'd1);

        // 4: three back-to-back frames, stop during the third
        apply_reset();
        push_bytes(6, 3);
        pulse_start();
        wait_strobes(2 * FBITS + 4);
        pulse_stop();
        wait_frames(3);
        wait_idle();
        chk("t4_frames", fd_cnt, 3);
        chk("t4_bank_count", bank_q.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < bank_q.size()) chk("t4_bank", {30'd0, bank_q[i]}, {30'd0, exp_bank[i]});
        chk("t4_gap_count", gap_q.size(), 2);
        foreach (gap_q[i]) chk("t4_gap_len", gap_q[i], GAP);
        foreach (flen_q[i]) chk("t4_frame_len", flen_q[i], FBITS);
        chk("t4_bits_consumed", exp_bits.size(), 0);
        chk("t4_no_underrun", {31'd0, underrun}, 32'd0);

        // 5: asynchronous reset in the middle of the second frame
        apply_reset();
        push_bytes(4, 2);
        pulse_start();
        wait_frames(1);
        wait_strobes(FBITS + 9);
        #2 reset = 1'b0;
        #1 chk("t5_async_reset", {22'd0, outs}, 32'd0);
        clear_model();
        @(negedge CLK_40);
        @(negedge CLK_40);
        reset = 1'b1;
        #1;
        b0 = 8'($urandom); b1 = 8'($urandom);
        it.dly = 0;
        it.b = b0; src_q.push_back(it);
        it.b = b1; src_q.push_back(it);
        pulse_start();
        pulse_stop();
        wait_frames(1);
        wait_idle();
        chk("t5_frame_len", flen_q.size() > 0 ? flen_q[0] : 32'hFFFF, FBITS);
        chk("t5_bits", {16'd0, rxq.size() > 0 ? rxq[0] : 16'hxxxx}, {16'd0, b0, b1});
        chk("t5_bank", {30'd0, read_bank1, read_bank2}, 32'd2);

        // 6: start+stop together in IDLE (start wins), then start during SHIFT
        apply_reset();
        push_bytes(4, 2);
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        wait_strobes(5);
        pulse_start();
        wait_strobes(FBITS + 4);
        pulse_stop();
        wait_frames(2);
        wait_idle();
        chk("t6_frames", fd_cnt, 2);
        chk("t6_selects", cs_rise, 2);
        foreach (flen_q[i]) chk("t6_frame_len", flen_q[i], FBITS);
        chk("t6_bank", {30'd0, read_bank1, read_bank2}, 32'd1);
        chk("t6_bits_consumed", exp_bits.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
